// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: state encoding,
// default Galois taps and the next-state function.
package lfsr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'h64;
    localparam int unsigned LFSR_MAX_W = 64;

    // Galois step for any width up to LFSR_MAX_W; bits at or above w come back zero.
    // Tap bit 0 is masked off because next[0] is always the feedback bit.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_nxt(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           w
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] shifted;
        logic [LFSR_MAX_W-1:0] mask;
        fb      = |(x & (LFSR_MAX_W'(1) << (w - 1)));
        shifted = {x[LFSR_MAX_W-2:0], fb};
        mask    = (LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1);
        return (shifted ^ ({LFSR_MAX_W{fb}} & taps & ~LFSR_MAX_W'(1))) & mask;
    endfunction

endpackage

// File: rtl/lfsr_next_comb.sv
// Purely combinational single-step Galois LFSR advance.
module lfsr_next_comb
    import lfsr_pkg::*;
#(
    parameter int unsigned          LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] TAPS      = LFSR_WIDTH'(LFSR_TAPS_DEFAULT)
) (
    input  logic [LFSR_WIDTH-1:0] i_x,
    output logic [LFSR_WIDTH-1:0] o_nxt
);

    logic [LFSR_MAX_W-1:0] w_full;

    assign w_full = lfsr_nxt(LFSR_MAX_W'(i_x), LFSR_MAX_W'(TAPS), LFSR_WIDTH);
    assign o_nxt  = w_full[LFSR_WIDTH-1:0];

endmodule

// File: rtl/lfsr_sync_checker.sv
// Self-synchronising Galois PRBS checker with lock/unlock hysteresis, flywheel
// prediction while locked, per-sample error strobe and saturating error count.
module lfsr_sync_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned           LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(LFSR_TAPS_DEFAULT),
    parameter int unsigned           LOCK_CNT   = 5,
    parameter int unsigned           UNLOCK_CNT = 3,
    parameter int unsigned           ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [LFSR_WIDTH-1:0] i_lfsr,
    input  logic                  i_clear_err,
    output logic                  o_lock,
    output logic                  o_err,
    output logic [ERR_WIDTH-1:0]  o_err_count
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    logic                  r_seeded;
    logic [GW-1:0]         r_good_cnt;
    logic [BW-1:0]         r_bad_cnt;
    logic [LFSR_WIDTH-1:0] r_expected;
    logic                  r_lock;
    logic                  r_err;
    logic [ERR_WIDTH-1:0]  r_err_count;

    logic [LFSR_WIDTH-1:0] w_nxt_in;
    logic [LFSR_WIDTH-1:0] w_nxt_exp;
    logic                  w_match;
    logic                  w_nonzero;
    logic [GW-1:0]         w_good_inc;
    logic [BW-1:0]         w_bad_inc;
    logic                  w_count_err;

    // Reset asserts asynchronously but releases on a clock edge to avoid
    // recovery/removal hazards on the state registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    lfsr_next_comb #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .TAPS       (TAPS)
    ) u_nxt_in (
        .i_x   (i_lfsr),
        .o_nxt (w_nxt_in)
    );

    lfsr_next_comb #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .TAPS       (TAPS)
    ) u_nxt_exp (
        .i_x   (r_expected),
        .o_nxt (w_nxt_exp)
    );

    assign w_match     = (i_lfsr == r_expected);
    assign w_nonzero   = |i_lfsr;
    assign w_good_inc  = r_good_cnt + GW'(1);
    assign w_bad_inc   = r_bad_cnt + BW'(1);
    assign w_count_err = i_valid && (r_state == LOCKED) && !w_match;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= SEARCH;
            r_seeded    <= 1'b0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_expected  <= '0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err <= 1'b0;
            if (i_valid) begin
                case (r_state)
                    SEARCH: begin
                        if (!r_seeded) begin
                            r_expected <= w_nxt_in;
                            r_seeded   <= 1'b1;
                        end else if (w_match && w_nonzero) begin
                            r_expected <= w_nxt_in;
                            if (w_good_inc == GW'(LOCK_CNT)) begin
                                r_state    <= LOCKED;
                                r_lock     <= 1'b1;
                                r_good_cnt <= '0;
                                r_bad_cnt  <= '0;
                            end else begin
                                r_good_cnt <= w_good_inc;
                            end
                        end else begin
                            // The all-zero word can never lead anywhere, so it reseeds too.
                            r_good_cnt <= '0;
                            r_expected <= w_nxt_in;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_bad_cnt  <= '0;
                            r_expected <= w_nxt_exp;
                        end else begin
                            r_err <= 1'b1;
                            if (w_bad_inc == BW'(UNLOCK_CNT)) begin
                                r_state    <= SEARCH;
                                r_lock     <= 1'b0;
                                r_seeded   <= 1'b1;
                                r_expected <= w_nxt_in;
                                r_good_cnt <= '0;
                                r_bad_cnt  <= '0;
                            end else begin
                                r_bad_cnt  <= w_bad_inc;
                                r_expected <= w_nxt_exp;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end

            if (i_clear_err) begin
                r_err_count <= '0;
            end else if (w_count_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERR_WIDTH'(1);
            end
        end
    end

    assign o_lock      = r_lock;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;

endmodule

// File: doc/lfsr_sync_checker.md
Name: lfsr_sync_checker

Overview:
- Parametrised self-synchronising checker for a Galois-form PRBS/LFSR stream.
- The polynomial, width, lock threshold and unlock threshold are all parameters.
- Adds a data-valid qualifier, a flywheel prediction while locked, a per-sample error strobe, and a saturating error counter with clear.
- Sits at the receive side of the LFSR test path, downstream of the LFSR generator, for link/BER checking.

Parameters:
- LFSR_WIDTH, 8, width of checked word (>=3).
- TAPS, 8'h64, Galois tap mask; bit i=1 means next[i] = cur[i-1] ^ fb. Bit 0 is ignored; next[0] = fb always.
- LOCK_CNT, 5, consecutive matching valid samples required to declare lock (>=1).
- UNLOCK_CNT, 3, consecutive mismatching valid samples while locked required to drop lock (>=1).
- ERR_WIDTH, 16, width of saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  i_lfsr carries a sample this cycle.
- i_lfsr  in  LFSR_WIDTH  received LFSR word.
- i_clear_err  in  1  synchronous clear of o_err_count.
- o_lock  out  1  checker locked.
- o_err  out  1  one-cycle pulse: the previous cycle's valid sample mismatched while locked.
- o_err_count  out  ERR_WIDTH  saturating count of locked-state mismatches.

Behaviour:
- Next-state function nxt(x):
  - fb = x[W-1]
  - nxt[0] = fb
  - nxt[i] = x[i-1] ^ (fb & TAPS[i]), for i = 1..W-1
- Reset (async assert, sync deassert internal to the design):
  - o_lock = 0, o_err = 0, o_err_count = 0
  - state = SEARCH, seeded = 0, good_cnt = 0, bad_cnt = 0, expected = 0
- Cycles with i_valid = 0: all state holds; o_err = 0.
- SEARCH, on a valid sample:
  - If seeded = 0: expected <= nxt(i_lfsr); seeded <= 1; good_cnt stays 0.
  - Else, if i_lfsr == expected and i_lfsr != 0:
    - good_cnt++, expected <= nxt(i_lfsr).
    - When good_cnt reaches LOCK_CNT: state <= LOCKED, o_lock <= 1 (visible the cycle after the LOCK_CNT-th match), good_cnt <= 0, bad_cnt <= 0.
  - Else (mismatch, or the all-zero lockup word): good_cnt <= 0; reseed expected <= nxt(i_lfsr).
  - o_err stays 0 and the error counter does not count in SEARCH.
- LOCKED, on a valid sample (flywheel: expected <= nxt(expected) regardless of input):
  - Match: bad_cnt <= 0.
  - Mismatch:
    - o_err <= 1 for one cycle.
    - o_err_count++ unless at all-ones (saturates, no wrap).
    - bad_cnt++.
    - When bad_cnt reaches UNLOCK_CNT: state <= SEARCH, o_lock <= 0, seeded <= 1, expected <= nxt(i_lfsr), good_cnt <= 0, bad_cnt <= 0.
  - Isolated mismatches below UNLOCK_CNT do not disturb the prediction.
- i_clear_err:
  - Sets o_err_count to 0 next cycle.
  - If a counted mismatch occurs in the same cycle, clear wins: the count becomes 0, but o_err still pulses.
- Latency: compare and update are single-cycle; all outputs are registered.
- Counter widths are $clog2(LOCK_CNT+1) and $clog2(UNLOCK_CNT+1).
- Reset asserted mid-stream: immediate return to reset values; reacquisition requires 1 seed sample + LOCK_CNT matches.

Decomposition:
- Shared package lfsr_pkg:
  - state encoding (SEARCH = 1'b0, LOCKED = 1'b1)
  - default TAPS constant 8'h64
  - a nxt() function parametrised by width/taps, shared with the generator.
- One natural sub-module, lfsr_next_comb: purely combinational nxt(), instantiated twice (input path and flywheel path).

Test Plan:
- Seed: TAPS = 8'h64, W = 8, valid every cycle with 01,02,04,08,10,20 (01 seeds; 02..20 are 5 matches) -> o_lock = 1 the cycle after 20; then 40,80,65 continue with o_err = 0.
- Single error: after lock, send 8'hFF in place of 40, then resume 80,65 -> one o_err pulse, o_err_count = 1, o_lock stays 1.
- Loss of lock: after lock, 3 consecutive corrupt words -> o_err pulses 3x, o_err_count = 3, o_lock = 0 after the third; a valid sequence then relocks after 1 seed + 5 matches.
- Gaps and lockup: i_valid toggling 1/0 with the sequence from the seed scenario -> lock after the same 6 valid samples; an all-zero stream -> o_lock never asserts.
- Saturation/clear: ERR_WIDTH = 2, 5 isolated mismatches while locked -> o_err_count holds 3; assert i_clear_err coincident with a mismatch -> o_err_count = 0, o_err = 1.
- Async reset while locked -> o_lock, o_err_count drop to 0 without a clock edge; relock after 6 valid samples.
